// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package hazard_pkg;
    localparam int REG_IDX_W = 5;
    localparam int FLAG_W    = 7;

    localparam int FLAG_REGWRITE = 0;
    localparam int FLAG_MEMREAD  = 1;
    localparam int FLAG_MEMWRITE = 2;
    localparam int FLAG_BRANCH   = 3;
    localparam int FLAG_JUMP     = 4;
    localparam int FLAG_ALUSRC   = 5;
    localparam int FLAG_MULDIV   = 6;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/execute operands in,
// latch enables/flushes and mul/div handshake out.
import hazard_pkg::*;

interface hazard_ctrl_if;
    logic [REG_IDX_W-1:0] s3_rs1;
    logic [REG_IDX_W-1:0] s3_rs2;
    logic                 s3_use_rs1;
    logic                 s3_use_rs2;
    logic [REG_IDX_W-1:0] s4_rd;
    logic [FLAG_W-1:0]    s4_flags;
    logic                 s4_redirect;
    logic                 md_done;
    logic                 pc_enable;
    logic                 en_s2s3;
    logic                 flush_s2s3;
    logic                 en_s3s4;
    logic                 flush_s3s4;
    logic                 en_s4s5;
    logic                 flush_s4s5;
    logic                 md_start;
    logic                 md_timeout;
    logic [31:0]          stall_count;

    modport master (
        output s3_rs1, s3_rs2, s3_use_rs1, s3_use_rs2, s4_rd, s4_flags,
               s4_redirect, md_done,
        input  pc_enable, en_s2s3, flush_s2s3, en_s3s4, flush_s3s4,
               en_s4s5, flush_s4s5, md_start, md_timeout, stall_count
    );

    modport slave (
        input  s3_rs1, s3_rs2, s3_use_rs1, s3_use_rs2, s4_rd, s4_flags,
               s4_redirect, md_done,
        output pc_enable, en_s2s3, flush_s2s3, en_s3s4, flush_s3s4,
               en_s4s5, flush_s4s5, md_start, md_timeout, stall_count
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: a load in execute whose destination is read in decode.
import hazard_pkg::*;

module hazard_detect (
    input  logic [REG_IDX_W-1:0] s3_rs1_i,
    input  logic [REG_IDX_W-1:0] s3_rs2_i,
    input  logic                 s3_use_rs1_i,
    input  logic                 s3_use_rs2_i,
    input  logic [REG_IDX_W-1:0] s4_rd_i,
    input  logic                 s4_memread_i,
    output logic                 load_hz_o
);
    logic rs1_hit, rs2_hit;

    assign rs1_hit   = s3_use_rs1_i && (s3_rs1_i == s4_rd_i);
    assign rs2_hit   = s3_use_rs2_i && (s3_rs2_i == s4_rd_i);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_hz_o = s4_memread_i && (s4_rd_i != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: load-use bubbles, mul/div wait with timeout and
// redirect flushes. Outputs are decoded combinationally from state and inputs.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MD_TIMEOUT        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    hz_state_e   state_q, state_d;
    logic [2:0]  ld_rem_q, ld_rem_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic        md_to_q, md_to_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        load_hz;
    logic        pc_en, en23, fl23, en34, fl34, en45, fl45, start;

    hazard_detect u_detect (
        .s3_rs1_i     (hz.s3_rs1),
        .s3_rs2_i     (hz.s3_rs2),
        .s3_use_rs1_i (hz.s3_use_rs1),
        .s3_use_rs2_i (hz.s3_use_rs2),
        .s4_rd_i      (hz.s4_rd),
        .s4_memread_i (hz.s4_flags[FLAG_MEMREAD]),
        .load_hz_o    (load_hz)
    );

    always_comb begin
        state_d  = state_q;
        ld_rem_d = ld_rem_q;
        md_cnt_d = md_cnt_q;
        md_to_d  = md_to_q;
        pc_en = 1'b1; en23 = 1'b1; en34 = 1'b1; en45 = 1'b1;
        fl23  = 1'b0; fl34 = 1'b0; fl45 = 1'b0; start = 1'b0;
        if (!rst_n) begin
            pc_en = 1'b0; en23 = 1'b0; en34 = 1'b0; en45 = 1'b0;
            fl23  = 1'b1; fl34 = 1'b1; fl45 = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.s4_redirect) begin
                        fl23 = 1'b1;
                        fl34 = 1'b1;
                    end else if (hz.s4_flags[FLAG_MULDIV]) begin
                        start = 1'b1;
                        pc_en = 1'b0; en23 = 1'b0; en34 = 1'b0; fl45 = 1'b1;
                        state_d  = MD_WAIT;
                        md_cnt_d = 8'd1;
                    end else if (load_hz) begin
                        pc_en = 1'b0; en23 = 1'b0; fl34 = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d  = LD_STALL;
                            ld_rem_d = 3'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                // Only bubbles sit in S4 here, so redirect cannot occur
                LD_STALL: begin
                    pc_en = 1'b0; en23 = 1'b0; fl34 = 1'b1;
                    ld_rem_d = ld_rem_q - 3'd1;
                    if (ld_rem_q == 3'd1) state_d = RUN;
                end
                MD_WAIT: begin
                    if (hz.md_done) begin
                        state_d = RUN;
                    end else if (md_cnt_q == 8'(MD_TIMEOUT)) begin
                        state_d = RUN;
                        md_to_d = 1'b1;
                    end else begin
                        pc_en = 1'b0; en23 = 1'b0; en34 = 1'b0; fl45 = 1'b1;
                        md_cnt_d = md_cnt_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ld_rem_q    <= '0;
            md_cnt_q    <= '0;
            md_to_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_rem_q    <= ld_rem_d;
            md_cnt_q    <= md_cnt_d;
            md_to_q     <= md_to_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_enable   = pc_en;
    assign hz.en_s2s3     = en23;
    assign hz.flush_s2s3  = fl23;
    assign hz.en_s3s4     = en34;
    assign hz.flush_s3s4  = fl34;
    assign hz.en_s4s5     = en45;
    assign hz.flush_s4s5  = fl45;
    assign hz.md_start    = start;
    assign hz.md_timeout  = md_to_q;
    assign hz.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers (1 and 3 load bubbles, mul/div timeout 8)
// share one stimulus; outputs packed as {pc,en23,fl23,en34,fl34,en45,fl45,start}.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] s3_rs1, s3_rs2, s4_rd;
    logic       s3_use_rs1, s3_use_rs2, s4_redirect, md_done;
    logic [6:0] s4_flags;
    int         checks = 0;
    int         errors = 0;

    localparam logic [7:0] O_IDLE  = 8'hD4;
    localparam logic [7:0] O_LDB   = 8'h1C;
    localparam logic [7:0] O_MDST  = 8'h07;
    localparam logic [7:0] O_MDW   = 8'h06;
    localparam logic [7:0] O_REDIR = 8'hFC;
    localparam logic [7:0] O_RST   = 8'h2A;

    always #5 clk = ~clk;

    hazard_ctrl_if if1 ();
    hazard_ctrl_if if3 ();

    assign if1.s3_rs1 = s3_rs1;  assign if3.s3_rs1 = s3_rs1;
    assign if1.s3_rs2 = s3_rs2;  assign if3.s3_rs2 = s3_rs2;
    assign if1.s3_use_rs1 = s3_use_rs1;  assign if3.s3_use_rs1 = s3_use_rs1;
    assign if1.s3_use_rs2 = s3_use_rs2;  assign if3.s3_use_rs2 = s3_use_rs2;
    assign if1.s4_rd = s4_rd;  assign if3.s4_rd = s4_rd;
    assign if1.s4_flags = s4_flags;  assign if3.s4_flags = s4_flags;
    assign if1.s4_redirect = s4_redirect;  assign if3.s4_redirect = s4_redirect;
    assign if1.md_done = md_done;  assign if3.md_done = md_done;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MD_TIMEOUT(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));
    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MD_TIMEOUT(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .hz(if3));

    logic [7:0] o1, o3;
    assign o1 = {if1.pc_enable, if1.en_s2s3, if1.flush_s2s3, if1.en_s3s4,
                 if1.flush_s3s4, if1.en_s4s5, if1.flush_s4s5, if1.md_start};
    assign o3 = {if3.pc_enable, if3.en_s2s3, if3.flush_s2s3, if3.en_s3s4,
                 if3.flush_s3s4, if3.en_s4s5, if3.flush_s4s5, if3.md_start};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s3_rs1 = 5'd0; s3_rs2 = 5'd0; s3_use_rs1 = 1'b0; s3_use_rs2 = 1'b0;
        s4_rd = 5'd0; s4_flags = 7'h00; s4_redirect = 1'b0; md_done = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_outs", 32'(o1), 32'(O_RST));
        chk("rst_stall_cnt", if1.stall_count, 32'd0);
        chk("rst_md_timeout", 32'(if1.md_timeout), 32'd0);
        step();
        rst_n = 1'b1;
        #1 chk("idle_outs", 32'(o1), 32'(O_IDLE));

        // load-use on rs1; dut3 ignores the redirect while bubbling
        step();
        s4_flags = 7'h03; s4_rd = 5'd5; s3_rs1 = 5'd5; s3_use_rs1 = 1'b1;
        #1 chk("ld1_bubble", 32'(o1), 32'(O_LDB));
        chk("ld3_bubble0", 32'(o3), 32'(O_LDB));
        step();
        idle(); s4_redirect = 1'b1;
        #1 chk("ld1_redir_after", 32'(o1), 32'(O_REDIR));
        chk("ld1_stall_cnt", if1.stall_count, 32'd1);
        chk("ld3_bubble1", 32'(o3), 32'(O_LDB));
        step();
        idle();
        #1 chk("ld3_bubble2", 32'(o3), 32'(O_LDB));
        chk("ld1_release", 32'(o1), 32'(O_IDLE));
        step();
        #1 chk("ld3_release", 32'(o3), 32'(O_IDLE));
        chk("ld3_stall_cnt", if3.stall_count, 32'd3);
        chk("ld1_stall_cnt_hold", if1.stall_count, 32'd1);

        // non-hazard cases, then an rs2 hazard
        do_reset();
        s4_flags = 7'h03; s4_rd = 5'd0; s3_rs1 = 5'd0; s3_use_rs1 = 1'b1;
        #1 chk("nohz_rd0", 32'(o1), 32'(O_IDLE));
        step();
        s4_rd = 5'd5; s3_rs1 = 5'd5; s3_use_rs1 = 1'b0;
        #1 chk("nohz_nouse", 32'(o1), 32'(O_IDLE));
        step();
        s4_flags = 7'h01; s3_use_rs1 = 1'b1;
        #1 chk("nohz_nomemrd", 32'(o1), 32'(O_IDLE));
        step();
        idle();
        #1 chk("nohz_stall_cnt", if1.stall_count, 32'd0);
        s4_flags = 7'h03; s4_rd = 5'd9; s3_rs2 = 5'd9; s3_use_rs2 = 1'b1;
        #1 chk("hz_rs2", 32'(o1), 32'(O_LDB));
        step();
        idle();

        // mul/div with md_done on the 6th waiting-state cycle
        do_reset();
        s4_flags = 7'h40;
        #1 chk("md_start", 32'(o1), 32'(O_MDST));
        for (int i = 1; i <= 5; i++) begin
            step();
            #1 chk($sformatf("md_wait%0d", i), 32'(o1), 32'(O_MDW));
        end
        step();
        md_done = 1'b1;
        #1 chk("md_release", 32'(o1), 32'(O_IDLE));
        step();
        idle();
        #1 chk("md_after", 32'(o1), 32'(O_IDLE));
        chk("md_stall_cnt", if1.stall_count, 32'd6);
        chk("md_no_timeout", 32'(if1.md_timeout), 32'd0);
        md_done = 1'b1;
        #1 chk("md_done_in_run", 32'(o1), 32'(O_IDLE));
        md_done = 1'b0;

        // mul/div timeout
        do_reset();
        s4_flags = 7'h40;
        #1 chk("to_start", 32'(o1), 32'(O_MDST));
        for (int i = 1; i <= 7; i++) begin
            step();
            #1 chk($sformatf("to_wait%0d", i), 32'(o1), 32'(O_MDW));
        end
        step();
        #1 chk("to_release", 32'(o1), 32'(O_IDLE));
        chk("to_flag_pre", 32'(if1.md_timeout), 32'd0);
        step();
        idle();
        #1 chk("to_flag", 32'(if1.md_timeout), 32'd1);
        chk("to_stall_cnt", if1.stall_count, 32'd8);
        step(); step();
        #1 chk("to_sticky", 32'(if1.md_timeout), 32'd1);

        // redirect beats load-use and mul/div
        s4_flags = 7'h03; s4_rd = 5'd5; s3_rs1 = 5'd5; s3_use_rs1 = 1'b1; s4_redirect = 1'b1;
        #1 chk("redir_vs_ld", 32'(o1), 32'(O_REDIR));
        step();
        idle(); s4_flags = 7'h40; s4_redirect = 1'b1;
        #1 chk("redir_vs_md", 32'(o1), 32'(O_REDIR));
        step();
        idle();
        #1 chk("redir_stall_cnt", if1.stall_count, 32'd8);

        // reset while waiting on mul/div
        s4_flags = 7'h40;
        #1 chk("mr_start", 32'(o1), 32'(O_MDST));
        step();
        #1 chk("mr_wait", 32'(o1), 32'(O_MDW));
        rst_n = 1'b0;
        #1 chk("mr_rst_outs", 32'(o1), 32'(O_RST));
        chk("mr_rst_timeout", 32'(if1.md_timeout), 32'd0);
        chk("mr_rst_stall_cnt", if1.stall_count, 32'd0);
        step();
        rst_n = 1'b1; idle();
        #1 chk("mr_run", 32'(o1), 32'(O_IDLE));
        step();
        #1 chk("mr_stall_cnt", if1.stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
